// File: rtl/stream_merger.sv
// stream_merger: buffers two unthrottled sample streams in per-channel FIFOs and
// re-pairs them in arrival order onto a 2*DATA_W valid/ready output.
module stream_merger #(
  parameter int DATA_W = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_MARGIN = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_W-1:0]                 data_port1,
  input  logic                              valid1,
  input  logic [DATA_W-1:0]                 data_port2,
  input  logic                              valid2,
  output logic [2*DATA_W-1:0]               master_data,
  output logic                              master_valid,
  input  logic                              master_ready,
  output logic                              in_ready,
  output logic                              ovf1,
  output logic                              ovf2,
  input  logic                              ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0]       level1,
  output logic [$clog2(FIFO_DEPTH):0]       level2
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  logic [DATA_W-1:0] din [2];
  logic [DATA_W-1:0] head [2];
  logic [LW-1:0] lvl [2];
  logic vin [2];
  logic ovf [2];
  logic pop;
  assign din[0] = data_port1;
  assign din[1] = data_port2;
  assign vin[0] = valid1;
  assign vin[1] = valid2;
  assign pop = (lvl[0] != '0) && (lvl[1] != '0) && (!master_valid || master_ready);
  genvar g;
  for (g = 0; g < 2; g++) begin : g_ch
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [LW-1:0] lv;
    logic ov, full, push;
    // A full FIFO still takes the sample when the head leaves in the same cycle.
    assign full = lv == LW'(FIFO_DEPTH);
    assign push = vin[g] && (!full || pop);
    assign head[g] = mem[rp];
    assign lvl[g] = lv;
    assign ovf[g] = ov;
    always_ff @(posedge clk)
      if (push) mem[wp] <= din[g];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        wp <= '0;
        rp <= '0;
        lv <= '0;
        ov <= 1'b0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop) rp <= rp + 1'b1;
        lv <= lv + LW'(push) - LW'(pop);
        ov <= (vin[g] && !push) || (ov && !ovf_clr);
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      master_data <= '0;
      master_valid <= 1'b0;
    end else if (pop) begin
      master_data <= {head[1], head[0]};
      master_valid <= 1'b1;
    end else if (master_ready) begin
      master_valid <= 1'b0;
    end
  assign in_ready = (lvl[0] <= LW'(FIFO_DEPTH - 1 - AF_MARGIN)) &&
                    (lvl[1] <= LW'(FIFO_DEPTH - 1 - AF_MARGIN));
  assign level1 = lvl[0];
  assign level2 = lvl[1];
  assign ovf1 = ovf[0];
  assign ovf2 = ovf[1];
endmodule

// File: tb/tb_stream_merger.sv
// tb_stream_merger: queue-based reference model feeding a scoreboard; a negedge
// monitor checks every output word plus levels, flags and in_ready.
module tb_stream_merger;
  localparam int DEPTH = 8;
  localparam int AF = 2;
  logic clk, rst_n;
  logic [31:0] data_port1, data_port2;
  logic valid1, valid2, master_ready, ovf_clr;
  logic [63:0] master_data;
  logic master_valid, in_ready, ovf1, ovf2;
  logic [3:0] level1, level2;
  int checks = 0;
  int errors = 0;

  stream_merger #(.DATA_W(32), .FIFO_DEPTH(DEPTH), .AF_MARGIN(AF)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_port1(data_port1), .valid1(valid1),
    .data_port2(data_port2), .valid2(valid2),
    .master_data(master_data), .master_valid(master_valid), .master_ready(master_ready),
    .in_ready(in_ready), .ovf1(ovf1), .ovf2(ovf2), .ovf_clr(ovf_clr),
    .level1(level1), .level2(level2)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two sample queues, a one-word output slot, and the list
  // of pairs the downstream side should see, in order.
  logic [31:0] q1[$], q2[$];
  logic [63:0] exp_q[$];
  bit m_mv, m_o1, m_o2, m_pop, m_a1, m_a2;
  logic [31:0] h1, h2;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q1.delete(); q2.delete(); exp_q.delete();
      m_mv = 0; m_o1 = 0; m_o2 = 0;
    end else begin
      m_pop = q1.size() > 0 && q2.size() > 0 && (!m_mv || master_ready);
      m_a1 = valid1 && (q1.size() < DEPTH || m_pop);
      m_a2 = valid2 && (q2.size() < DEPTH || m_pop);
      if (m_pop) begin
        h1 = q1.pop_front();
        h2 = q2.pop_front();
        exp_q.push_back({h2, h1});
        m_mv = 1;
      end else if (master_ready) m_mv = 0;
      if (m_a1) q1.push_back(data_port1);
      if (m_a2) q2.push_back(data_port2);
      m_o1 = (valid1 && !m_a1) || (m_o1 && !ovf_clr);
      m_o2 = (valid2 && !m_a2) || (m_o2 && !ovf_clr);
    end
  end

  always @(negedge clk) if (rst_n) begin
    chk("master_valid", master_valid, m_mv);
    chk("level1", level1, q1.size());
    chk("level2", level2, q2.size());
    chk("ovf1", ovf1, m_o1);
    chk("ovf2", ovf2, m_o2);
    chk("in_ready", in_ready, q1.size() <= DEPTH - 1 - AF && q2.size() <= DEPTH - 1 - AF);
    if (master_valid && master_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL data: got %h expected no word at %0t", master_data, $time);
      end else chk("data", master_data, exp_q.pop_front());
    end
  end

  task automatic cyc(input bit v1, input bit v2, input logic [31:0] d1, input logic [31:0] d2,
                     input bit rdy, input bit clr);
    valid1 = v1; valid2 = v2; data_port1 = d1; data_port2 = d2;
    master_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_valid"}, master_valid, 0);
    chk({tag, "_data"}, master_data, 0);
    chk({tag, "_level1"}, level1, 0);
    chk({tag, "_level2"}, level2, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_ovf"}, {ovf1, ovf2}, 0);
  endtask

  initial begin
    rst_n = 0;
    valid1 = 0; valid2 = 0; data_port1 = 0; data_port2 = 0;
    master_ready = 0; ovf_clr = 0;
    #12;
    reset_chk("rst");
    rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) cyc(1, 1, 32'h11111111 + i, 32'hAAAAAAA0 + i, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);
    chk("t1_level1", level1, 0);
    for (int i = 1; i <= 3; i++) cyc(1, 0, i, 0, 1, 0);
    chk("t2_level1", level1, 3);
    chk("t2_level2", level2, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 32'hA + i, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);
    chk("t2_ovf", {ovf1, ovf2}, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, 32'h300 + i, 32'h400 + i, 0, 0);
    chk("t3_level1", level1, 8);
    chk("t3_level2", level2, 8);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_ovf", {ovf1, ovf2}, 2'b11);
    chk("t3_hold", master_data, 64'h00000400_00000300);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t3_clr", {ovf1, ovf2}, 0);
    cyc(1, 1, 32'h5A5A, 32'h6B6B, 1, 0);
    chk("t4_level1", level1, 8);
    chk("t4_ovf", {ovf1, ovf2}, 0);
    for (int i = 0; i < 14; i++) cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) cyc(1, 1, 32'h700 + i, 32'h800 + i, 0, 0);
    chk("t5_level1", level1, 5);
    #2 rst_n = 0;
    #1 reset_chk("t5_async");
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    cyc(1, 1, 32'h55, 32'h66, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("t5_new", master_data, 64'h00000066_00000055);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, $urandom, $urandom,
          $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 1, 0);
    chk("drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
